// File: rtl/vga_scan_out_pkg.sv
// Shared VGA types, default 640x480@60 timing and the test-pattern bar helper.
// Pure declarations: no latency, no backpressure.
package vga_pkg;
    localparam int COORD_W      = 10;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIPE_LAT = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Raw, active-high versions of the pin flags; all-zero is the idle/blank state.
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } flags_t;

    // bar_bits = x[8:6]: one full-scale primary per bit.
    function automatic rgb_t bar_colour(input logic [2:0] bar_bits);
        rgb_t c;
        c.r = {8{bar_bits[0]}};
        c.g = {8{bar_bits[1]}};
        c.b = {8{bar_bits[2]}};
        return c;
    endfunction
endpackage

// File: rtl/vga_scan_out_if.sv
// Coordinate/colour exchange with the layer mux plus the DAC pin bundle.
// No latency of its own; the video path has no backpressure.
interface vga_scan_out_if;
    import vga_pkg::*;

    rgb_t                rgb_in;
    logic [COORD_W-1:0]  pix_x;
    logic [COORD_W-1:0]  pix_y;
    logic                pix_active;
    logic                frame_start;
    logic                vga_hs_n;
    logic                vga_vs_n;
    logic                vga_blank_n;
    logic                vga_sync_n;
    logic [7:0]          vga_r;
    logic [7:0]          vga_g;
    logic [7:0]          vga_b;
`ifdef VGA_TEST_PATTERN_EN
    logic                test_en;
`endif

    modport master (
        input  rgb_in,
`ifdef VGA_TEST_PATTERN_EN
        input  test_en,
`endif
        output pix_x, pix_y, pix_active, frame_start,
        output vga_hs_n, vga_vs_n, vga_blank_n, vga_sync_n,
        output vga_r, vga_g, vga_b
    );

    modport slave (
        output rgb_in,
`ifdef VGA_TEST_PATTERN_EN
        output test_en,
`endif
        input  pix_x, pix_y, pix_active, frame_start,
        input  vga_hs_n, vga_vs_n, vga_blank_n, vga_sync_n,
        input  vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_delay_line.sv
// Shift register of DEPTH stages (DEPTH=0 is a wire), async reset to RST_VAL.
// Latency DEPTH cycles; always shifts, no backpressure.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    generate
        if (DEPTH == 0) begin : g_wire
            assign o_q = i_d;
        end else begin : g_sr
            logic [WIDTH-1:0] r_sr [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
                end else begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_scan_out.sv
// VGA raster counters, sync/blank generation and registered colour out; VGA_TEST_PATTERN_EN adds colour bars.
// Pins lag the issued coordinate by PIPE_LAT+1 cycles; free-running, no backpressure.
module vga_scan_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic          clk,
    input  logic          rst,
    vga_scan_out_if.master vga
);
    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [COORD_W-1:0] r_h_cnt;
    logic [COORD_W-1:0] r_v_cnt;
    flags_t             w_flags;
    flags_t             w_flags_lat;
    flags_t             w_flags_pin;
    rgb_t               w_rgb_next;
    rgb_t               r_rgb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == COORD_W'(H_TOT - 1)) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == COORD_W'(V_TOT - 1)) ? '0 : r_v_cnt + COORD_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + COORD_W'(1);
        end
    end

    always_comb begin
        w_flags.hs     = (r_h_cnt >= COORD_W'(HS_START)) && (r_h_cnt < COORD_W'(HS_END));
        w_flags.vs     = (r_v_cnt >= COORD_W'(VS_START)) && (r_v_cnt < COORD_W'(VS_END));
        w_flags.active = (r_h_cnt < COORD_W'(H_ACTIVE)) && (r_v_cnt < COORD_W'(V_ACTIVE));
    end

    // The PIPE_LAT tap lines up with rgb_in; one more stage lines up with the colour register.
    vga_delay_line #(.WIDTH($bits(flags_t)), .DEPTH(PIPE_LAT), .RST_VAL('0)) u_flags_lat (
        .clk (clk),
        .rst (rst),
        .i_d (w_flags),
        .o_q (w_flags_lat)
    );

    vga_delay_line #(.WIDTH($bits(flags_t)), .DEPTH(1), .RST_VAL('0)) u_flags_pin (
        .clk (clk),
        .rst (rst),
        .i_d (w_flags_lat),
        .o_q (w_flags_pin)
    );

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar_lat;

    vga_delay_line #(.WIDTH(3), .DEPTH(PIPE_LAT), .RST_VAL('0)) u_bar_lat (
        .clk (clk),
        .rst (rst),
        .i_d (r_h_cnt[8:6]),
        .o_q (w_bar_lat)
    );
`endif

    always_comb begin
        w_rgb_next = vga.rgb_in;
`ifdef VGA_TEST_PATTERN_EN
        if (vga.test_en) w_rgb_next = bar_colour(w_bar_lat);
`endif
        if (!w_flags_lat.active) w_rgb_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rgb <= '0;
        else     r_rgb <= w_rgb_next;
    end

    assign vga.pix_x       = r_h_cnt;
    assign vga.pix_y       = r_v_cnt;
    assign vga.pix_active  = w_flags.active;
    assign vga.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign vga.vga_hs_n    = ~w_flags_pin.hs;
    assign vga.vga_vs_n    = ~w_flags_pin.vs;
    assign vga.vga_blank_n = w_flags_pin.active;
    assign vga.vga_sync_n  = 1'b0;
    assign vga.vga_r       = r_rgb.r;
    assign vga.vga_g       = r_rgb.g;
    assign vga.vga_b       = r_rgb.b;
endmodule
